// File: rtl/priv_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : priv_mode_ctrl
// Description : Privilege-mode controller. Holds the current privilege level
//               (U/S/M) and the mstatus stacking fields (MPP/SPP, MIE/SIE,
//               MPIE/SPIE). Updates them on trap entry, including
//               medeleg/mideleg delegation to S, and on mret/sret. Flags
//               illegal returns.
// Ports       : clk, reset_x (async, active-low), enable (pipeline advance)
//               i_trap/i_trapIsIntr/i_trapCause  trap request and cause
//               i_medeleg/i_mideleg              delegation masks
//               i_mret/i_sret                    return instructions
//               i_statusWe/i_statusWdata         CSR write, mstatus[12:0]
//               o_nowPrivMode, o_status          registered state view
//               o_trapToS, o_retIllegal,
//               o_intrEnM, o_intrEnS             combinational status
// Revision    : 1.0 - initial release
// ============================================================================
module priv_mode_ctrl #(
  parameter int          HAS_SMODE  = 1,
  parameter int          CAUSE_W    = 5,
  parameter logic [1:0]  RESET_MODE = 2'b00
) (
  input  logic                    clk,
  input  logic                    reset_x,
  input  logic                    enable,
  input  logic                    i_trap,
  input  logic                    i_trapIsIntr,
  input  logic [CAUSE_W-1:0]      i_trapCause,
  input  logic [(2**CAUSE_W)-1:0] i_medeleg,
  input  logic [(2**CAUSE_W)-1:0] i_mideleg,
  input  logic                    i_mret,
  input  logic                    i_sret,
  input  logic                    i_statusWe,
  input  logic [12:0]             i_statusWdata,
  output logic [1:0]              o_nowPrivMode,
  output logic [12:0]             o_status,
  output logic                    o_trapToS,
  output logic                    o_retIllegal,
  output logic                    o_intrEnM,
  output logic                    o_intrEnS
);

  localparam int         MASK_W = 2**CAUSE_W;
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic       S_IMPL = (HAS_SMODE != 0);

  // Architectural state
  logic [1:0] priv_q, priv_d;
  logic [1:0] mpp_q,  mpp_d;
  logic       mie_q,  mie_d;
  logic       mpie_q, mpie_d;
  logic       sie_q,  sie_d;
  logic       spie_q, spie_d;
  logic       spp_q,  spp_d;

  logic [MASK_W-1:0] deleg_mask;
  logic              trap_to_s;
  logic              mret_ok;
  logic              sret_ok;
  logic [1:0]        wr_mpp;
  logic              wr_mpp_keep;

  // Reserved mstatus bits carry no state; folded here so they are visibly
  // consumed.
  logic unused_wdata;
  assign unused_wdata = ^{i_statusWdata[10:9], i_statusWdata[6],
                          i_statusWdata[4], i_statusWdata[2], i_statusWdata[0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      priv_q <= RESET_MODE;
      mpp_q  <= PRIV_U;
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
      sie_q  <= 1'b0;
      spie_q <= 1'b0;
      spp_q  <= 1'b0;
    end else begin
      priv_q <= priv_d;
      mpp_q  <= mpp_d;
      mie_q  <= mie_d;
      mpie_q <= mpie_d;
      sie_q  <= sie_d;
      spie_q <= spie_d;
      spp_q  <= spp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Decode of requests against the current state
  // --------------------------------------------------------------------------
  always_comb begin
    deleg_mask  = i_trapIsIntr ? i_mideleg : i_medeleg;
    // Traps taken while in M never delegate downwards.
    trap_to_s   = i_trap & S_IMPL & (priv_q != PRIV_M) & deleg_mask[i_trapCause];
    mret_ok     = (priv_q == PRIV_M);
    sret_ok     = S_IMPL & (priv_q != PRIV_U);
    wr_mpp      = i_statusWdata[12:11];
    // MPP is WARL: reserved encoding 10, and S when S is absent, are ignored.
    wr_mpp_keep = (wr_mpp == 2'b10) | ((wr_mpp == PRIV_S) & ~S_IMPL);
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Priority: trap > mret > sret > status write.
  // --------------------------------------------------------------------------
  always_comb begin
    priv_d = priv_q;
    mpp_d  = mpp_q;
    mie_d  = mie_q;
    mpie_d = mpie_q;
    sie_d  = sie_q;
    spie_d = spie_q;
    spp_d  = spp_q;
    if (enable) begin
      if (i_trap) begin
        if (trap_to_s) begin
          spp_d  = priv_q[0];
          spie_d = sie_q;
          sie_d  = 1'b0;
          priv_d = PRIV_S;
        end else begin
          mpp_d  = priv_q;
          mpie_d = mie_q;
          mie_d  = 1'b0;
          priv_d = PRIV_M;
        end
      end else if (i_mret) begin
        if (mret_ok) begin
          priv_d = mpp_q;
          mie_d  = mpie_q;
          mpie_d = 1'b1;
          mpp_d  = PRIV_U;
        end
      end else if (i_sret) begin
        if (sret_ok) begin
          priv_d = spp_q ? PRIV_S : PRIV_U;
          sie_d  = spie_q;
          spie_d = 1'b1;
          spp_d  = 1'b0;
        end
      end else if (i_statusWe) begin
        mie_d  = i_statusWdata[3];
        mpie_d = i_statusWdata[7];
        sie_d  = i_statusWdata[1] & S_IMPL;
        spie_d = i_statusWdata[5] & S_IMPL;
        spp_d  = i_statusWdata[8] & S_IMPL;
        if (!wr_mpp_keep) begin
          mpp_d = wr_mpp;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_nowPrivMode = priv_q;
    o_status      = {mpp_q, 2'b00, spp_q, mpie_q, 1'b0, spie_q, 1'b0,
                     mie_q, 1'b0, sie_q, 1'b0};
    o_trapToS     = trap_to_s;
    // mret outranks sret, so a simultaneous sret is never the one judged.
    o_retIllegal  = i_mret ? ~mret_ok : (i_sret & ~sret_ok);
    o_intrEnM     = (priv_q != PRIV_M) | mie_q;
    o_intrEnS     = S_IMPL & ((priv_q == PRIV_U) | ((priv_q == PRIV_S) & sie_q));
  end

endmodule
`default_nettype wire

// File: doc/priv_mode_ctrl.md
# priv_mode_ctrl

Parametrised privilege-mode controller: the next generation of the plain privilege-mode register. It tracks the current privilege level (U/S/M) and owns the mstatus stacking fields (MPP/SPP, MIE/SIE, MPIE/SPIE). It updates them on trap entry with medeleg/mideleg delegation and on mret/sret, and flags illegal returns. It sits between the trap/exception unit, the CSR file and the pipeline control, and replaces the bare privilege register.

## Interface
- HAS_SMODE, 1, 1 = S-mode implemented; 0 = U/M only.
- CAUSE_W, 5, width of trap cause code; delegation masks are 2**CAUSE_W bits.
- RESET_MODE, 2'b00, privilege level loaded on reset (00 U, 01 S, 11 M).

- clk  in  1  clock, all state on rising edge.
- reset_x  in  1  asynchronous, active-low reset.
- enable  in  1  pipeline advance; 0 freezes all state.
- i_trap  in  1  take trap this cycle.
- i_trapIsIntr  in  1  1 = interrupt, 0 = exception.
- i_trapCause  in  CAUSE_W  cause code, indexes delegation mask.
- i_medeleg  in  2**CAUSE_W  exception delegation mask.
- i_mideleg  in  2**CAUSE_W  interrupt delegation mask.
- i_mret  in  1  mret retiring.
- i_sret  in  1  sret retiring.
- i_statusWe  in  1  CSR write to mstatus/sstatus fields.
- i_statusWdata  in  13  write data, mstatus[12:0] layout.
- o_nowPrivMode  out  2  current privilege (registered).
- o_status  out  13  mstatus[12:0] view: bit1 SIE, 3 MIE, 5 SPIE, 7 MPIE, 8 SPP, 12:11 MPP, others 0 (registered).
- o_trapToS  out  1  combinational: the pending trap targets S (selects stvec).
- o_retIllegal  out  1  combinational: the current mret/sret is illegal.
- o_intrEnM  out  1  combinational: M-level interrupts globally enabled.
- o_intrEnS  out  1  combinational: S-level interrupts globally enabled.

## Operation
- Reset (reset_x=0, async): priv=RESET_MODE, all status fields 0 (MPP=00).
- Delegation: o_trapToS = HAS_SMODE & (priv!=11) & mask[i_trapCause]. The mask is i_mideleg if i_trapIsIntr, else i_medeleg. Computed whenever i_trap=1; forced 0 when i_trap=0.
- Trap to M: MPP<=priv, MPIE<=MIE, MIE<=0, priv<=11.
- Trap to S: SPP<=priv[0], SPIE<=SIE, SIE<=0, priv<=01.
- mret is legal iff priv==11. Legal mret: priv<=MPP, MIE<=MPIE, MPIE<=1, MPP<=00.
- sret is legal iff HAS_SMODE and priv!=00. Legal sret: priv<=(SPP ? 01 : 00), SIE<=SPIE, SPIE<=1, SPP<=0.
- Illegal return: o_retIllegal=1 and no state change. The exception unit raises the illegal-instruction trap in a later cycle.
- Status write: updates SIE, MIE, SPIE, MPIE, SPP and MPP from i_statusWdata.
  - MPP is WARL. Value 10 keeps the old MPP. Value 01 with HAS_SMODE=0 also keeps the old MPP.
  - With HAS_SMODE=0, SIE/SPIE/SPP are hardwired 0 and ignore writes.
- Priority when several requests are asserted in one enabled cycle: i_trap > i_mret > i_sret > i_statusWe. Only the highest-priority request acts; the rest are dropped.
- o_intrEnM = (priv!=11) | MIE.
- o_intrEnS = HAS_SMODE & ((priv==00) | (priv==01 & SIE)).

## Timing
- All updates occur at the rising clk edge with enable=1. Registered outputs show the new value the following cycle (1-cycle latency).
- enable=0: no update, regardless of requests. Combinational outputs still track inputs and current state.
- Combinational outputs use the current registered state. A trap and the next trap in back-to-back cycles see the already-updated priv.
- Async reset mid-operation: state goes immediately to reset values. An in-flight trap/return is lost.

## Test plan
- Reset with RESET_MODE=00 -> o_nowPrivMode=00, o_status=0. Release reset, then i_trap, cause 8, medeleg=0, enable=1 -> next cycle priv=11, MPP=00, MIE=0, o_trapToS=0 during the trap cycle.
- From U, medeleg[8]=1, trap cause 8 -> o_trapToS=1 combinationally; next cycle priv=01, SPP=0, SIE=0, SPIE=old SIE. Repeat from M with the same mask -> o_trapToS=0, priv stays 11.
- From M with MPP=01, MPIE=1 via status write 13'h0880, then mret -> priv=01, MIE=1, MPIE=1, MPP=00. Then sret with SPP=0 -> priv=00, SPIE=1.
- Illegal returns: mret in S, sret in U, and sret with HAS_SMODE=0 -> o_retIllegal=1, state unchanged next cycle.
- Same-cycle i_trap and i_mret in M -> only the trap acts (MPP=11, MIE=0). With enable=0, trap asserted -> no change.
- WARL: write MPP=10 -> MPP holds its old value. With HAS_SMODE=0, write 13'h0922 -> SIE/SPIE/SPP read 0.
